// File: rtl/sys_gpio_in_edgecap.sv
// GPIO input port with synchroniser, optional debounce filter, edge capture and irq.
// Define GPIO_IN_DEBOUNCE_EN to build the per-bit debounce filter between sync and filt.
module sys_gpio_in_edgecap #(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned IRQ_TYPE        = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CAP  = 2'd3;

`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
   localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
`endif
   localparam int unsigned WARM_W = $clog2(WARM_CYCLES + 1);

   // Elaboration-time parameter range checks
   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("WIDTH out of range 1..32");
      end
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("SYNC_STAGES out of range 2..4");
      end
      if (EDGE_TYPE > 2) begin : g_bad_edge
         $error("EDGE_TYPE out of range 0..2");
      end
      if (IRQ_TYPE > 1) begin : g_bad_irq
         $error("IRQ_TYPE out of range 0..1");
      end
      if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
         $error("DEBOUNCE_CYCLES out of range 1..65535");
      end
      if (WIDTH < 32) begin : g_wd_upper
         logic unused_wd_upper;
         assign unused_wd_upper = ^writedata[31:WIDTH];
      end
   endgenerate

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync;
   logic [WIDTH-1:0]                  filt;
   logic [WIDTH-1:0]                  filt_d;
   logic [WIDTH-1:0]                  edge_raw;
   logic [WIDTH-1:0]                  edge_hit;
   logic [WIDTH-1:0]                  irq_mask;
   logic [WIDTH-1:0]                  irq_mask_next;
   logic [WIDTH-1:0]                  edge_capture;
   logic [WIDTH-1:0]                  edge_capture_next;
   logic [WARM_W-1:0]                 warm_cnt;
   logic                              warm_done;
   logic                              wr_en;
   logic [31:0]                       rd_mux;
   logic                              irq_next;

   // Metastability synchroniser chain
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0][CNT_W-1:0] db_cnt;
   logic [WIDTH-1:0]            filt_q;

   // A bit flips only after sync has disagreed with it for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filt_q <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != filt_q[i]) begin
               if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  filt_q[i] <= ~filt_q[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + CNT_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign filt = filt_q;
`else
   assign filt = sync;
`endif

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_raw = filt & ~filt_d;
         1:       edge_raw = ~filt & filt_d;
         default: edge_raw = filt ^ filt_d;
      endcase
   end

   // Pipeline contents right after reset are not real input history
   assign warm_done = (warm_cnt == '0);
   assign edge_hit  = warm_done ? edge_raw : '0;
   assign wr_en     = chipselect & ~write_n;

   // Register updates; on a clear-vs-set collision the new edge wins
   always_comb begin
      irq_mask_next     = irq_mask;
      edge_capture_next = edge_capture | edge_hit;
      if (wr_en && address == ADDR_MASK) begin
         irq_mask_next = writedata[WIDTH-1:0];
      end
      if (wr_en && address == ADDR_CAP) begin
         edge_capture_next = (edge_capture & ~writedata[WIDTH-1:0]) | edge_hit;
      end
   end

   always_comb begin
      case (address)
         ADDR_DATA: rd_mux = 32'(filt);
         ADDR_MASK: rd_mux = 32'(irq_mask);
         ADDR_CAP:  rd_mux = 32'(edge_capture);
         default:   rd_mux = 32'd0;
      endcase
   end

   always_comb begin
      if (IRQ_TYPE == 0) begin
         irq_next = |(filt & irq_mask_next);
      end else begin
         irq_next = |(edge_capture_next & irq_mask_next);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filt_d       <= '0;
         irq_mask     <= '0;
         edge_capture <= '0;
         warm_cnt     <= WARM_W'(WARM_CYCLES);
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         filt_d       <= filt;
         irq_mask     <= irq_mask_next;
         edge_capture <= edge_capture_next;
         if (!warm_done) begin
            warm_cnt <= warm_cnt - WARM_W'(1);
         end
         readdata     <= rd_mux;
         irq          <= irq_next;
      end
   end

endmodule
